muap_collector: RTL and testbench
=================================

// Module: muap_collector
// PURPOSE
//  Receiving end of the spike-detector muap stream (muap_valid/frame_No/ch/ch_hash/data, no backpressure).
//  Groups N_BEATS consecutive beats sharing (frame_No, ch) into one spike and buffers it.
//  Emits it to the host-side DMA path as a framed 32-bit valid/ready/last packet: 3 header words + N_BEATS data words.
//  Input cannot be stalled: a spike that does not fit is dropped whole; a spike cut short is discarded.
// PARAMETERS
//  N_BEATS  76  data beats per spike (>=2)
//  DATA_AW  10  data buffer address width; depth 2**DATA_AW words (must be >= N_BEATS)
//  HDR_AW   4   header FIFO address width; 2**HDR_AW committed spikes max
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous reset, active low
//  muap_valid     in   1   input beat valid, sampled every cycle
//  muap_frame_No  in   32  frame number of spike
//  muap_ch        in   12  channel of spike
//  muap_ch_hash   in   32  channel-group hash
//  muap_data      in   32  waveform sample
//  pkt_tdata      out  32  output word
//  pkt_tvalid     out  1   output word valid
//  pkt_tready     in   1   downstream ready
//  pkt_tlast      out  1   last word of packet
//  drop_cnt       out  16  spikes dropped for lack of space (wraps)
//  abort_cnt      out  16  spikes discarded as short (wraps)
//  busy           out  1   spike being received or packet pending/in flight
// BEHAVIOUR
//  - Reset: all outputs 0; pointers, counters, FSMs cleared; buffered and partial spikes lost.
//  - Receive FSM: IDLE, FILL, DROP.
//  - IDLE + valid (first beat): latch {frame_No,ch,ch_hash}; beat_cnt=1.
//    - Space OK (data free >= N_BEATS, header FIFO not full): write beat at wr_ptr, go FILL.
//    - Otherwise: drop_cnt+1, go DROP.
//  - FILL/DROP + valid, same (frame_No,ch): write (FILL only), beat_cnt+1.
//    - beat_cnt reaches N_BEATS: FILL commits; both states return to IDLE.
//  - FILL/DROP + valid, different (frame_No,ch): current spike ends.
//    - FILL: abort_cnt+1, wr_ptr rolled back to commit_ptr.
//    - DROP: nothing counted.
//    - Same cycle, beat treated as first beat of a new spike (space check as in IDLE).
//  - Gaps (valid=0) inside a spike are allowed and do not abort.
//  - Commit: cycle after last beat, push header to header FIFO; commit_ptr=wr_ptr. Data pointers wrap mod 2**DATA_AW.
//  - Space check counts only committed+unread words; read pops free space same cycle it is checked (read wins).
//  - Transmit FSM: IDLE, H0, H1, H2, DATA.
//    - Words: H0={16'hA55A,4'b0,ch}, H1=frame_No, H2=ch_hash, then N_BEATS samples in arrival order.
//    - Word advances only when pkt_tvalid&pkt_tready; tdata/tlast stable while valid&!ready.
//    - pkt_tvalid rises no later than 2 cycles after commit. tready held 1: whole packet back-to-back, no bubbles.
//    - tlast on final data word; next packet H0 may follow next cycle.
//  - Simultaneous commit and packet completion: both honoured same cycle.
//  - busy=1 when receive FSM!=IDLE, header FIFO non-empty, or transmit FSM!=IDLE.
// CONFIGURATION
//  MUAP_COLLECT_TRAILER_EN defined:
//    - Trailer word appended after last data word = XOR of all H0..data words of the packet.
//    - tlast moves to trailer; packet length N_BEATS+4.
//  Not defined: no trailer, packet length N_BEATS+3, tlast on last data word.
// TESTING
//  1 Reset, 76 beats frame=100 ch=5 hash=0x0F0E0D0C data=0..75, tready=1
//    -> 79 words A55A0005,100,0F0E0D0C,0..75; tlast on 75; drop=abort=0.
//  2 Two spikes back-to-back (frames 7,8), tready=0 until both commit, then 1
//    -> two intact packets in order, no gap between them.
//  3 ch changes after 30 beats, then full 76-beat spike
//    -> abort_cnt=1; only the second spike is output; 31st beat is its data[0].
//  4 DATA_AW=7 (128 words), tready=0, send 3 spikes
//    -> 1 packet buffered, drop_cnt=2; release tready -> exactly 1 packet out.
//  5 Random tready ~50% over 20 spikes
//    -> stream matches model; no word changes while valid&!ready.
//  6 rst_n pulsed low mid-FILL and mid-transmit
//    -> outputs 0 at once; next spike after release emitted cleanly.
//  With MUAP_COLLECT_TRAILER_EN, test 1: word 80 = XOR of words 1..79, tlast on it.

Source files
------------

// File: rtl/muap_collector_if.sv
// Muap beat stream (no backpressure) plus framed valid/ready/last packet stream of the collector.
// The collector uses the slave modport; the environment driving beats and sinking packets uses master.
interface muap_collector_if;
   logic        muap_valid;
   logic [31:0] muap_frame_No;
   logic [11:0] muap_ch;
   logic [31:0] muap_ch_hash;
   logic [31:0] muap_data;
   logic [31:0] pkt_tdata;
   logic        pkt_tvalid;
   logic        pkt_tready;
   logic        pkt_tlast;

   modport master (
      output muap_valid, muap_frame_No, muap_ch, muap_ch_hash, muap_data, pkt_tready,
      input  pkt_tdata, pkt_tvalid, pkt_tlast
   );
   modport slave (
      input  muap_valid, muap_frame_No, muap_ch, muap_ch_hash, muap_data, pkt_tready,
      output pkt_tdata, pkt_tvalid, pkt_tlast
   );
endinterface

// File: rtl/muap_collector.sv
// Groups N_BEATS muap beats per (frame_No, ch) into spikes and emits them as framed 32-bit packets.
// Define MUAP_COLLECT_TRAILER_EN to append an XOR trailer word to every packet.
module muap_collector #(
   parameter int unsigned N_BEATS = 76,
   parameter int unsigned DATA_AW = 10,
   parameter int unsigned HDR_AW  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   muap_collector_if.slave        bus,
   output logic            [15:0] drop_cnt,
   output logic            [15:0] abort_cnt,
   output logic                   busy
);
   localparam int unsigned DEPTH  = 1 << DATA_AW;
   localparam int unsigned HDEPTH = 1 << HDR_AW;
   localparam int unsigned BW     = $clog2(N_BEATS + 1);
   localparam logic [DATA_AW:0] MAX_USED  = (DATA_AW + 1)'(DEPTH - N_BEATS);
   localparam logic [DATA_AW:0] PTR_ONE   = (DATA_AW + 1)'(1);
   localparam logic [HDR_AW:0]  HDR_FULL  = (HDR_AW + 1)'(HDEPTH);
   localparam logic [HDR_AW:0]  HPTR_ONE  = (HDR_AW + 1)'(1);
   localparam logic [BW-1:0]    LAST_BEAT = BW'(N_BEATS - 1);
   localparam logic [BW-1:0]    BEAT_ONE  = BW'(1);

   localparam logic [1:0] RX_IDLE = 2'd0, RX_FILL = 2'd1, RX_DROP = 2'd2;
   localparam logic [2:0] TX_IDLE = 3'd0, TX_H0 = 3'd1, TX_H1 = 3'd2, TX_H2 = 3'd3, TX_DATA = 3'd4;
`ifdef MUAP_COLLECT_TRAILER_EN
   localparam logic [2:0] TX_TRL = 3'd5;
`endif

   logic [1:0]       rx_st_q, rx_st_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic [31:0]      key_frame_q, key_frame_d, key_hash_q, key_hash_d;
   logic [11:0]      key_ch_q, key_ch_d;
   logic [DATA_AW:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d, wr_base, used_eff;
   logic             commit_q, commit_d;
   logic [15:0]      drop_q, drop_d, abort_q, abort_d;
   logic [HDR_AW:0]  hdr_wp_q, hdr_wp_d, hdr_rp_q, hdr_rp_d, hdr_used;
   logic [2:0]       tx_q, tx_d;
   logic [75:0]      cur_q, cur_d;
   logic [BW-1:0]    dcnt_q, dcnt_d;
   logic [31:0]      mem_q [DEPTH];
   logic [75:0]      hdr_mem_q [HDEPTH];
   logic             mem_we, key_match, space_ok, hs, rd_pop, hdr_pop, hdr_avail, tvalid;
   logic [DATA_AW-1:0] mem_wa;

   // wr_base is the end of committed data: rolled back while filling, pending commit included
   assign wr_base   = (rx_st_q == RX_FILL) ? cmt_ptr_q : wr_ptr_q;
   assign used_eff  = wr_base - rd_ptr_q - {{DATA_AW{1'b0}}, rd_pop};
   assign hdr_used  = hdr_wp_q - hdr_rp_q + {{HDR_AW{1'b0}}, commit_q};
   assign space_ok  = (used_eff <= MAX_USED) && (hdr_used < HDR_FULL);
   assign key_match = (bus.muap_frame_No == key_frame_q) && (bus.muap_ch == key_ch_q);
   assign hdr_avail = (hdr_wp_q != hdr_rp_q);
   assign tvalid    = (tx_q != TX_IDLE);
   assign hs        = tvalid & bus.pkt_tready;

   always_comb begin
      rx_st_d     = rx_st_q;
      beat_d      = beat_q;
      key_frame_d = key_frame_q;
      key_ch_d    = key_ch_q;
      key_hash_d  = key_hash_q;
      wr_ptr_d    = wr_ptr_q;
      drop_d      = drop_q;
      abort_d     = abort_q;
      commit_d    = 1'b0;
      mem_we      = 1'b0;
      mem_wa      = wr_ptr_q[DATA_AW-1:0];
      cmt_ptr_d   = commit_q ? wr_ptr_q : cmt_ptr_q;
      hdr_wp_d    = commit_q ? hdr_wp_q + HPTR_ONE : hdr_wp_q;
      if (bus.muap_valid) begin
         if (rx_st_q != RX_IDLE && key_match) begin
            beat_d = beat_q + BEAT_ONE;
            if (rx_st_q == RX_FILL) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (beat_q == LAST_BEAT) begin
               rx_st_d  = RX_IDLE;
               commit_d = (rx_st_q == RX_FILL);
            end
         end else begin
            if (rx_st_q == RX_FILL) abort_d = abort_q + 16'd1;
            key_frame_d = bus.muap_frame_No;
            key_ch_d    = bus.muap_ch;
            key_hash_d  = bus.muap_ch_hash;
            beat_d      = BEAT_ONE;
            if (space_ok) begin
               rx_st_d  = RX_FILL;
               mem_we   = 1'b1;
               mem_wa   = wr_base[DATA_AW-1:0];
               wr_ptr_d = wr_base + PTR_ONE;
            end else begin
               rx_st_d  = RX_DROP;
               drop_d   = drop_q + 16'd1;
               wr_ptr_d = wr_base;
            end
         end
      end
   end

   always_comb begin
      tx_d     = tx_q;
      cur_d    = cur_q;
      dcnt_d   = dcnt_q;
      rd_ptr_d = rd_ptr_q;
      hdr_rp_d = hdr_rp_q;
      rd_pop   = 1'b0;
      hdr_pop  = 1'b0;
      case (tx_q)
         TX_IDLE: hdr_pop = hdr_avail;
         TX_H0:   if (hs) tx_d = TX_H1;
         TX_H1:   if (hs) tx_d = TX_H2;
         TX_H2: begin
            if (hs) begin
               tx_d   = TX_DATA;
               dcnt_d = '0;
            end
         end
         TX_DATA: begin
            if (hs) begin
               rd_pop   = 1'b1;
               rd_ptr_d = rd_ptr_q + PTR_ONE;
               dcnt_d   = dcnt_q + BEAT_ONE;
               if (dcnt_q == LAST_BEAT) begin
`ifdef MUAP_COLLECT_TRAILER_EN
                  tx_d = TX_TRL;
`else
                  tx_d    = TX_IDLE;
                  hdr_pop = hdr_avail;
`endif
               end
            end
         end
`ifdef MUAP_COLLECT_TRAILER_EN
         TX_TRL: begin
            if (hs) begin
               tx_d    = TX_IDLE;
               hdr_pop = hdr_avail;
            end
         end
`endif
         default: tx_d = TX_IDLE;
      endcase
      // Chaining straight into H0 keeps back-to-back packets free of bubbles
      if (hdr_pop) begin
         cur_d    = hdr_mem_q[hdr_rp_q[HDR_AW-1:0]];
         hdr_rp_d = hdr_rp_q + HPTR_ONE;
         tx_d     = TX_H0;
      end
   end

`ifdef MUAP_COLLECT_TRAILER_EN
   logic [31:0] xor_q, xor_d;
   always_comb begin
      xor_d = xor_q;
      if (hs) xor_d = (tx_q == TX_H0) ? bus.pkt_tdata : xor_q ^ bus.pkt_tdata;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) xor_q <= '0;
      else        xor_q <= xor_d;
   end
`endif

   always_comb begin
      bus.pkt_tdata = '0;
      bus.pkt_tlast = 1'b0;
      case (tx_q)
         TX_H0:   bus.pkt_tdata = {16'hA55A, 4'b0, cur_q[75:64]};
         TX_H1:   bus.pkt_tdata = cur_q[63:32];
         TX_H2:   bus.pkt_tdata = cur_q[31:0];
         TX_DATA: begin
            bus.pkt_tdata = mem_q[rd_ptr_q[DATA_AW-1:0]];
`ifndef MUAP_COLLECT_TRAILER_EN
            bus.pkt_tlast = (dcnt_q == LAST_BEAT);
`endif
         end
`ifdef MUAP_COLLECT_TRAILER_EN
         TX_TRL: begin
            bus.pkt_tdata = xor_q;
            bus.pkt_tlast = 1'b1;
         end
`endif
         default: bus.pkt_tdata = '0;
      endcase
   end

   assign bus.pkt_tvalid = tvalid;
   assign drop_cnt       = drop_q;
   assign abort_cnt      = abort_q;
   assign busy           = (rx_st_q != RX_IDLE) || commit_q || hdr_avail || tvalid;

   always_ff @(posedge clk) begin
      if (mem_we)   mem_q[mem_wa] <= bus.muap_data;
      if (commit_q) hdr_mem_q[hdr_wp_q[HDR_AW-1:0]] <= {key_ch_q, key_frame_q, key_hash_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st_q     <= RX_IDLE;
         beat_q      <= '0;
         key_frame_q <= '0;
         key_ch_q    <= '0;
         key_hash_q  <= '0;
         wr_ptr_q    <= '0;
         cmt_ptr_q   <= '0;
         rd_ptr_q    <= '0;
         commit_q    <= 1'b0;
         drop_q      <= '0;
         abort_q     <= '0;
         hdr_wp_q    <= '0;
         hdr_rp_q    <= '0;
         tx_q        <= TX_IDLE;
         cur_q       <= '0;
         dcnt_q      <= '0;
      end else begin
         rx_st_q     <= rx_st_d;
         beat_q      <= beat_d;
         key_frame_q <= key_frame_d;
         key_ch_q    <= key_ch_d;
         key_hash_q  <= key_hash_d;
         wr_ptr_q    <= wr_ptr_d;
         cmt_ptr_q   <= cmt_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         commit_q    <= commit_d;
         drop_q      <= drop_d;
         abort_q     <= abort_d;
         hdr_wp_q    <= hdr_wp_d;
         hdr_rp_q    <= hdr_rp_d;
         tx_q        <= tx_d;
         cur_q       <= cur_d;
         dcnt_q      <= dcnt_d;
      end
   end
endmodule

// File: tb/tb_muap_collector.sv
// Self-checking bench for muap_collector: spike-level model with a packet scoreboard plus directed checks.
// Honours MUAP_COLLECT_TRAILER_EN the same way as the design.
module tb_muap_collector;
   localparam int NB    = 76;
   localparam int DAW   = 8;
   localparam int HAW   = 4;
   localparam int DEPTH = 1 << DAW;
`ifdef MUAP_COLLECT_TRAILER_EN
   localparam int PLEN = NB + 4;
`else
   localparam int PLEN = NB + 3;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] drop_cnt, abort_cnt;
   logic        busy;
   always #5 clk = ~clk;

   muap_collector_if bus();

   muap_collector #(.N_BEATS(NB), .DATA_AW(DAW), .HDR_AW(HAW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .drop_cnt(drop_cnt), .abort_cnt(abort_cnt), .busy(busy)
   );

   int total = 0;
   int bad = 0;
   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   typedef struct {logic [31:0] d; bit last; bit is_data;} word_t;
   word_t       exp_q[$];
   logic [31:0] got_q[$];
   bit          got_last_q[$];
   int          m_used = 0, m_cnt = 0, stall = 0, hs_cnt = 0, last_cnt = 0;
   bit          m_active = 0, m_acc = 0, held = 0;
   logic [31:0] m_frame, m_hash, held_d;
   logic [11:0] m_ch;
   logic [31:0] m_buf [NB];
   logic [15:0] m_drop = 0, m_abort = 0;
   bit          held_l;
   int          tr_mode = 0;

   task automatic push_word(input logic [31:0] d, input bit last, input bit is_data);
      word_t w;
      w.d = d; w.last = last; w.is_data = is_data;
      exp_q.push_back(w);
   endtask

   task automatic push_pkt();
      logic [31:0] x;
      x = {16'hA55A, 4'b0, m_ch} ^ m_frame ^ m_hash;
      push_word({16'hA55A, 4'b0, m_ch}, 0, 0);
      push_word(m_frame, 0, 0);
      push_word(m_hash, 0, 0);
      for (int i = 0; i < NB; i++) begin
         x ^= m_buf[i];
`ifdef MUAP_COLLECT_TRAILER_EN
         push_word(m_buf[i], 0, 1);
`else
         push_word(m_buf[i], i == NB - 1, 1);
`endif
      end
`ifdef MUAP_COLLECT_TRAILER_EN
      push_word(x, 1, 0);
`endif
   endtask

   // Model and scoreboard, evaluated between active edges
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_used = 0; m_active = 0; m_drop = 0; m_abort = 0; stall = 0; held = 0;
      end else begin
         chk("drop_cnt", drop_cnt, m_drop);
         chk("abort_cnt", abort_cnt, m_abort);
         if (held) begin
            chk("hold_tvalid", bus.pkt_tvalid, 1);
            chk("hold_tdata", bus.pkt_tdata, held_d);
            chk("hold_tlast", bus.pkt_tlast, held_l);
         end
         held = bus.pkt_tvalid && !bus.pkt_tready;
         held_d = bus.pkt_tdata;
         held_l = bus.pkt_tlast;
         if (exp_q.size() == 0) begin
            chk("spurious_tvalid", bus.pkt_tvalid, 0);
         end else if (!bus.pkt_tvalid) begin
            stall++;
            if (stall > 3) begin
               chk("tvalid_latency", bus.pkt_tvalid, 1);
               stall = 0;
            end
         end else begin
            stall = 0;
            if (bus.pkt_tready) begin
               word_t w;
               w = exp_q.pop_front();
               chk("tdata", bus.pkt_tdata, w.d);
               chk("tlast", bus.pkt_tlast, w.last);
               if (w.is_data) m_used--;
               got_q.push_back(bus.pkt_tdata);
               got_last_q.push_back(bus.pkt_tlast);
               hs_cnt++;
               if (bus.pkt_tlast) last_cnt++;
            end
         end
         if (bus.muap_valid) begin
            if (m_active && bus.muap_frame_No == m_frame && bus.muap_ch == m_ch) begin
               if (m_acc) m_buf[m_cnt] = bus.muap_data;
               m_cnt++;
               if (m_cnt == NB) begin
                  if (m_acc) begin
                     push_pkt();
                     m_used += NB;
                  end
                  m_active = 0;
               end
            end else begin
               if (m_active && m_acc) m_abort++;
               m_frame = bus.muap_frame_No; m_ch = bus.muap_ch; m_hash = bus.muap_ch_hash;
               m_cnt = 1; m_active = 1;
               m_acc = (DEPTH - m_used) >= NB;
               if (!m_acc) m_drop++;
               m_buf[0] = bus.muap_data;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (tr_mode)
         0:       bus.pkt_tready = 1'b0;
         1:       bus.pkt_tready = 1'b1;
         default: bus.pkt_tready = 1'($urandom_range(1));
      endcase
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         bus.muap_valid = 1'b0;
      end
   endtask

   task automatic spike(input logic [31:0] fr, input logic [11:0] ch, input logic [31:0] hash,
                        input logic [31:0] d0, input int n, input bit rnd, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(99) < gap_pct) idle(1);
         @(posedge clk); #1;
         bus.muap_valid = 1'b1;
         bus.muap_frame_No = fr; bus.muap_ch = ch; bus.muap_ch_hash = hash;
         bus.muap_data = rnd ? $urandom : d0 + i;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #2;
      chk({name, "_drained"}, exp_q.size(), 0);
      chk({name, "_busy"}, busy, 0);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_tvalid"}, bus.pkt_tvalid, 0);
      chk({name, "_tdata"}, bus.pkt_tdata, 0);
      chk({name, "_tlast"}, bus.pkt_tlast, 0);
      chk({name, "_drop"}, drop_cnt, 0);
      chk({name, "_abort"}, abort_cnt, 0);
      chk({name, "_busy"}, busy, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int h0, l0, n;
      bus.muap_valid = 1'b0;
      bus.muap_frame_No = '0; bus.muap_ch = '0; bus.muap_ch_hash = '0; bus.muap_data = '0;
      repeat (3) @(posedge clk);
      #2;
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      // 1: single spike, tready held high
      tr_mode = 1;
      got_q.delete(); got_last_q.delete();
      spike(100, 5, 32'h0F0E0D0C, 0, NB, 0, 0);
      idle(1);
      drain("t1");
      chk("t1_len", got_q.size(), PLEN);
      chk("t1_h0", got_q[0], 32'hA55A0005);
      chk("t1_h1", got_q[1], 100);
      chk("t1_h2", got_q[2], 32'h0F0E0D0C);
      chk("t1_d0", got_q[3], 0);
      chk("t1_dlast", got_q[NB + 2], 75);
      chk("t1_tlast_end", got_last_q[PLEN - 1], 1);
      chk("t1_tlast_early", got_last_q[PLEN - 2], 0);
`ifdef MUAP_COLLECT_TRAILER_EN
      chk("t1_trailer", got_q[NB + 3], 32'hAA540D6D);
`endif
      chk("t1_drop", drop_cnt, 0);
      chk("t1_abort", abort_cnt, 0);

      // 2: two spikes buffered, then released back-to-back
      tr_mode = 0;
      spike(7, 1, 32'h11, 1000, NB, 0, 0);
      spike(8, 1, 32'h22, 2000, NB, 0, 0);
      idle(5);
      #1;
      chk("t2_waiting", bus.pkt_tvalid, 1);
      @(posedge clk); #2;
      h0 = hs_cnt; l0 = last_cnt;
      tr_mode = 1;
      repeat (2 * PLEN + 1) @(posedge clk);
      #2;
      chk("t2_no_bubble", hs_cnt - h0, 2 * PLEN);
      chk("t2_packets", last_cnt - l0, 2);
      drain("t2");

      // 3: short spike aborted by a channel change
      got_q.delete(); got_last_q.delete();
      spike(20, 3, 32'h33, 500, 30, 0, 0);
      spike(20, 4, 32'h44, 900, NB, 0, 0);
      idle(1);
      drain("t3");
      chk("t3_abort", abort_cnt, 1);
      chk("t3_len", got_q.size(), PLEN);
      chk("t3_h0", got_q[0], 32'hA55A0004);
      chk("t3_d0", got_q[3], 900);

      // 4: buffer holds three spikes, the rest are dropped whole
      tr_mode = 0;
      for (int k = 0; k < 5; k++) spike(30 + k, 2, 32'h55, 100 * k, NB, 0, 0);
      idle(3);
      #1;
      chk("t4_drop", drop_cnt, 2);
      chk("t4_busy", busy, 1);
      l0 = last_cnt;
      tr_mode = 1;
      drain("t4");
      chk("t4_packets", last_cnt - l0, 3);

      // 5: random tready, random gaps inside spikes
      tr_mode = 2;
      for (int k = 0; k < 20; k++) begin
         spike(1000 + k, 12'($urandom_range(4095)), $urandom, 0, NB, 1, 10);
         idle(200);
      end
      drain("t5");

      // 6: reset mid-fill and mid-transmit
      tr_mode = 1;
      spike(50, 9, 32'h66, 0, 40, 0, 0);
      @(posedge clk); #1;
      bus.muap_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_zero("t6_fill_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      spike(51, 9, 32'h77, 0, NB, 0, 0);
      idle(1);
      h0 = hs_cnt; n = 0;
      while (hs_cnt - h0 < 20 && n < 500) begin
         @(posedge clk);
         n++;
      end
      chk("t6_tx_started", hs_cnt - h0 >= 20, 1);
      #1 rst_n = 1'b0;
      #1;
      chk_zero("t6_tx_rst");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      got_q.delete(); got_last_q.delete();
      spike(52, 9, 32'h88, 300, NB, 0, 0);
      idle(1);
      drain("t6");
      chk("t6_len", got_q.size(), PLEN);
      chk("t6_h1", got_q[1], 52);
      chk("t6_d0", got_q[3], 300);

      chk("final_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
